// File: rtl/seqdiv32by16.sv
// rtl/seqdiv32by16.sv - iterative restoring divider, DW-bit dividend by VW-bit divisor
// Optional macro: SEQDIV_ZERO_CHECK_EN (divide-by-zero fast path and dz flag)
module seqdiv32by16 #(
    parameter int DW = 32,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic          dz
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] d_q, d_d;
    logic [VW-1:0] v_q, v_d;
    logic [VW-1:0] r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
`ifdef SEQDIV_ZERO_CHECK_EN
    logic          dz_q, dz_d;
`endif

    logic [VW:0]   s;
    logic          ge;

    // S < 2*V whenever the subtract happens, so the low VW bits are the exact difference
    assign s  = {r_q, d_q[DW-1]};
    assign ge = (s >= {1'b0, v_q});

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        v_d     = v_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef SEQDIV_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = dividend;
                    v_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SEQDIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend[VW-1:0];
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                r_d   = ge ? (s[VW-1:0] - v_q) : s[VW-1:0];
                d_d   = {d_q[DW-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                    quot_d  = d_d;
                    rem_d   = r_d;
`ifdef SEQDIV_ZERO_CHECK_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef SEQDIV_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            v_q     <= v_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef SEQDIV_ZERO_CHECK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign quot = quot_q;
    assign rem  = rem_q;
`ifdef SEQDIV_ZERO_CHECK_EN
    assign dz   = dz_q;
`else
    assign dz   = 1'b0;
`endif

endmodule

// File: tb/tb_seqdiv32by16.sv
// tb/tb_seqdiv32by16.sv - scoreboard bench for seqdiv32by16 (honours SEQDIV_ZERO_CHECK_EN)
module tb_seqdiv32by16;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy, done, dz;
    logic [31:0] quot;
    logic [15:0] rem;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_done = 0;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];

`ifdef SEQDIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    seqdiv32by16 dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .dividend(dividend),
        .divisor (divisor),
        .busy    (busy),
        .done    (done),
        .quot    (quot),
        .rem     (rem),
        .dz      (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance to the next falling edge and score any completion seen there
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
            n_done++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
            end else begin
                e = sb.pop_front();
                checks += 4;
                if (quot !== e.q) begin
                    errors++;
                    $display("FAIL quot: got %h expected %h", quot, e.q);
                end
                if (rem !== e.r) begin
                    errors++;
                    $display("FAIL rem: got %h expected %h", rem, e.r);
                end
                if (dz !== e.dz) begin
                    errors++;
                    $display("FAIL dz: got %b expected %b", dz, e.dz);
                end
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int start_cyc);
        exp_t e;
        if (b == 16'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a[15:0];
            e.dz  = ZC;
            e.cyc = start_cyc + 1 + (ZC ? 0 : 32);
        end else begin
            e.q   = a / {16'd0, b};
            e.r   = 16'(a % {16'd0, b});
            e.dz  = 1'b0;
            e.cyc = start_cyc + 33;
        end
        return e;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [15:0] er);
        exp_t e;
        e = model(a, b, cyc);
        e.q = eq;
        e.r = er;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        checks++;
        if (!(ZC && b == 16'd0) && busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL op_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        clr_n    = 1'b0;
        start    = 1'b1;
        dividend = 32'h1234_5678;
        divisor  = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy: got %b expected 0", busy);
            end
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_done: got %b expected 0", done);
            end
        end
        checks += 3;
        if (quot !== 32'd0) begin
            errors++;
            $display("FAIL reset_quot: got %h expected 0", quot);
        end
        if (rem !== 16'd0) begin
            errors++;
            $display("FAIL reset_rem: got %h expected 0", rem);
        end
        if (dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_dz: got %b expected 0", dz);
        end
        start = 1'b0;
        clr_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        do_op(32'h0001_E240, 16'h0064, 32'h0000_04D2, 16'h0038);
    endtask

    task automatic test_extremes();
        logic [31:0] a;
        logic [15:0] b;
        exp_t e;
        do_op(32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000);
        do_op(32'hFFFE_0001, 16'hFFFF, 32'h0000_FFFF, 16'h0000);
        do_op(32'd5, 16'd7, 32'd0, 16'd5);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = 16'($urandom_range(1, 65535));
            e = model(a, b, 0);
            do_op(a, b, e.q, e.r);
        end
    endtask

    task automatic test_ignored_start();
        exp_t e;
        int   d0;
        e = model(32'h0BAD_F00D, 16'h0123, cyc);
        sb.push_back(e);
        d0       = n_done;
        start    = 1'b1;
        dividend = 32'h0BAD_F00D;
        divisor  = 16'h0123;
        tick();
        start = 1'b0;
        for (int k = 1; k < 45; k++) begin
            start    = (k == 4 || k == 31);
            dividend = 32'h0000_0007;
            divisor  = 16'h0002;
            tick();
        end
        start = 1'b0;
        checks += 2;
        if (n_done - d0 != 1) begin
            errors++;
            $display("FAIL ignored_start_dones: got %0d expected 1", n_done - d0);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ignored_start_pending: got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] a;
        logic [15:0] b;
        int          d0;
        d0    = n_done;
        start = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            a = $urandom;
            b = 16'($urandom_range(1, 65535));
            if (k == 0 || k == 34 || k == 68) begin
                e = model(a, b, cyc);
                sb.push_back(e);
            end
            dividend = a;
            divisor  = b;
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks += 2;
        if (n_done - d0 != 3) begin
            errors++;
            $display("FAIL back_to_back_dones: got %0d expected 3", n_done - d0);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_pending: got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        e = model(32'hDEAD_BEEF, 16'h1234, 0);
        do_op(32'hDEAD_BEEF, 16'h1234, e.q, e.r);
        start    = 1'b1;
        dividend = 32'h8765_4321;
        divisor  = 16'h0011;
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        clr_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: got %b expected 0", busy);
        end
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done: got %b expected 0", done);
        end
        if (quot !== 32'd0) begin
            errors++;
            $display("FAIL midreset_quot: got %h expected 0", quot);
        end
        if (rem !== 16'd0) begin
            errors++;
            $display("FAIL midreset_rem: got %h expected 0", rem);
        end
        tick();
        tick();
        clr_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        e = model(32'h8765_4321, 16'h0011, 0);
        do_op(32'h8765_4321, 16'h0011, e.q, e.r);
    endtask

    task automatic test_div_zero();
        do_op(32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678);
        // A nonzero divisor afterwards must clear dz again
        do_op(32'd1000, 16'd3, 32'd333, 16'd1);
    endtask

    initial begin
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        clr_n    = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_div_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
